mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2: memory wait cycles per access, legal range 1..15.
REQ-002 SHALL have parameter STATE_W, default 8: StateOut width.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports in order:
- Clk  in  1  clock.
- Reset_signal  in  1  synchronous active-high reset.
REQ-004 SHALL have the following remaining ports:
- Op  in  6  opcode, IR[31:26].
- Funct  in  6  function field, IR[5:0].
- ALU_zero  in  1  ALU result zero.
- ALU_overflow  in  1  ALU signed overflow.
- StateOut  out  STATE_W  current state code, registered.
- PC_load  out  1  = PCWrite | (PCWriteCond & (ALU_zero ^ BranchNe)).
- PCWrite, PCWriteCond, BranchNe  out  1 each  PC write controls.
- wr  out  1  memory write.
- IorD, IRWrite, RegWrite, RegDst, ALUSrcA, A_load, B_load, MDR_load, ALUOut_load, EPCWrite, RegReset  out  1 each  datapath strobes.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 imm<<16.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALU_sel  out  3  001 ADD, 010 SUB, 011 AND, 110 XOR, 000 pass/idle.
- Halted  out  1  high while in HALT.

Function
REQ-005 SHALL be a Moore FSM. All outputs except PC_load and StateOut SHALL decode combinationally from state only. Unlisted outputs are 0.
REQ-006 SHALL implement states and transitions:
- RESET -> FETCH.
- FETCH -> MEMW.
- MEMW: waits on a wait counter, then -> DECODE.
- DECODE -> by Op/Funct.
- R_EXEC -> R_WB; R_WB -> FETCH.
- BRANCH -> FETCH.
- ADDR -> LW_RD (Op 0x23) or SW_WR (Op 0x2b).
- LW_RD -> LW_WB after MEM_WAIT cycles; LW_WB -> FETCH.
- SW_WR -> FETCH after MEM_WAIT cycles.
- LUI_WB -> FETCH.
- JUMP -> FETCH.
- EXCEPT -> FETCH.
- HALT -> HALT.
REQ-007 FETCH/MEMW SHALL drive IorD=0, MDR_load=1, IRWrite=1. On the last MEMW cycle only they SHALL also drive ALUSrcA=0, ALUSrcB=01, ALU_sel=001, PCSource=00, PCWrite=1.
REQ-008 The wait counter SHALL be 4 bits. It loads MEM_WAIT-1 on entry to MEMW, LW_RD or SW_WR and decrements each cycle. The state exits when the counter reads 0. Each such state lasts exactly MEM_WAIT cycles.
REQ-009 DECODE SHALL drive A_load=1, B_load=1, ALUOut_load=1, ALUSrcA=0, ALUSrcB=11, ALU_sel=001.
REQ-010 DECODE with Op=0 SHALL dispatch on Funct:
- 0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR -> R_EXEC.
- 0x00 NOP -> FETCH.
- 0x0d BREAK -> HALT.
- any other Funct -> EXCEPT.
REQ-011 DECODE with Op!=0 SHALL dispatch on Op:
- 0x04/0x05 -> BRANCH.
- 0x23/0x2b -> ADDR.
- 0x0f -> LUI_WB.
- 0x02 -> JUMP.
- any other Op -> EXCEPT.
REQ-012 The Funct/Op codes captured in DECODE SHALL be held in an internal register. R_EXEC ALU_sel and BranchNe SHALL use this register, not live inputs.
REQ-013 R_EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALU_sel per funct, ALUOut_load=1.
REQ-014 R_EXEC with ALU_overflow=1 on ADD/SUB SHALL go to EXCEPT instead of R_WB. RegWrite SHALL never assert for that instruction.
REQ-015 R_WB SHALL drive RegWrite=1, RegDst=1, MemtoReg=00.
REQ-016 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALU_sel=010, PCSource=01, PCWriteCond=1, and BranchNe=1 for Op 0x05.
REQ-017 ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALU_sel=001, ALUOut_load=1.
REQ-018 LW_RD SHALL drive IorD=1, MDR_load=1. LW_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=01.
REQ-019 SW_WR SHALL drive IorD=1 and wr=1 for all MEM_WAIT cycles.
REQ-020 LUI_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=10.
REQ-021 JUMP SHALL drive PCSource=10, PCWrite=1.
REQ-022 EXCEPT SHALL drive EPCWrite=1, PCSource=11, PCWrite=1.
REQ-023 HALT SHALL be left only by Reset_signal.

Reset
REQ-024 Reset_signal=1 at any clock edge SHALL force state=RESET and wait counter=0, overriding any transition, including mid-MEMW and mid-SW_WR.
REQ-025 In RESET, RegReset=1 and all other strobes SHALL be 0. The state after reset deasserts SHALL be FETCH on the next edge.
REQ-026 StateOut SHALL reset to the RESET code one cycle after reset asserts.

Structure
REQ-027 The state enum, opcode and funct localparams, and ALU_sel codes SHALL live in a shared package mips_ctrl_pkg.
REQ-028 The wait counter SHALL be a sub-module mem_wait_counter (load, decrement, zero flag).

Verification
REQ-029 Reset then ADD, no overflow -> FETCH..FETCH takes MEM_WAIT+4=6 cycles; RegWrite=1 with RegDst=1 in cycle 6 only.
REQ-030 MEM_WAIT=4, LW -> MEMW lasts 4 cycles and LW_RD lasts 4 cycles; MemtoReg=01 with RegWrite in LW_WB; total 12 cycles.
REQ-031 BNE with ALU_zero=0 -> PC_load=1 in BRANCH. BEQ with ALU_zero=0 -> PC_load=0.
REQ-032 SUB with ALU_overflow=1 in R_EXEC -> EXCEPT next cycle, EPCWrite=1, PCSource=11, and no RegWrite anywhere.
REQ-033 Op=0x3f -> EXCEPT. Funct=0x0d -> HALT with Halted held for 20 cycles; Reset_signal -> RESET, then FETCH.
REQ-034 Reset_signal asserted in the 2nd SW_WR cycle -> wr=0 on the next cycle and state=RESET.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes,
// opcode/funct values, ALU selects and the decode dispatch helper.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_MEMW   = 4'd2,
        S_DECODE = 4'd3,
        S_R_EXEC = 4'd4,
        S_R_WB   = 4'd5,
        S_BRANCH = 4'd6,
        S_ADDR   = 4'd7,
        S_LW_RD  = 4'd8,
        S_LW_WB  = 4'd9,
        S_SW_WR  = 4'd10,
        S_LUI_WB = 4'd11,
        S_JUMP   = 4'd12,
        S_EXCEPT = 4'd13,
        S_HALT   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_BREAK = 6'h0d;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_XOR   = 6'h26;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    function automatic logic [2:0] funct_alu(input logic [5:0] funct);
        logic [2:0] sel;
        case (funct)
            FN_ADD:  sel = ALU_ADD;
            FN_SUB:  sel = ALU_SUB;
            FN_AND:  sel = ALU_AND;
            FN_XOR:  sel = ALU_XOR;
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

    function automatic logic is_addsub(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

    function automatic state_t dispatch(input logic [5:0] op,
                                        input logic [5:0] funct);
        state_t s;
        s = S_EXCEPT;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_SUB, FN_AND, FN_XOR: s = S_R_EXEC;
                FN_NOP:   s = S_FETCH;
                FN_BREAK: s = S_HALT;
                default:  s = S_EXCEPT;
            endcase
        end else begin
            case (op)
                OP_BEQ, OP_BNE: s = S_BRANCH;
                OP_LW, OP_SW:   s = S_ADDR;
                OP_LUI:         s = S_LUI_WB;
                OP_J:           s = S_JUMP;
                default:        s = S_EXCEPT;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// 4-bit down counter timing memory accesses; load wins over decrement
// and the count parks at zero.
module mem_wait_counter (
    input  logic       Clk,
    input  logic       Reset_signal,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    assign zero = (count == 4'd0);

    always_ff @(posedge Clk) begin
        if (Reset_signal) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 4'd1;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with memory wait
// states, overflow/illegal-opcode exceptions and a BREAK halt.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int STATE_W  = 8
) (
    input  logic               Clk,
    input  logic               Reset_signal,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               ALU_zero,
    input  logic               ALU_overflow,
    output logic [STATE_W-1:0] StateOut,
    output logic               PC_load,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               wr,
    output logic               IorD,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic               A_load,
    output logic               B_load,
    output logic               MDR_load,
    output logic               ALUOut_load,
    output logic               EPCWrite,
    output logic               RegReset,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALU_sel,
    output logic               Halted
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [3:0] wait_cnt;
    logic       wait_zero;
    logic       wait_load;
    logic       wait_dec;

    always_ff @(posedge Clk) begin
        if (Reset_signal) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Later states must see the instruction fields captured at decode.
    always_ff @(posedge Clk) begin
        if (Reset_signal) begin
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else if (state == S_DECODE) begin
            op_q    <= Op;
            funct_q <= Funct;
        end
    end

    assign wait_dec  = (state == S_MEMW) || (state == S_LW_RD) ||
                       (state == S_SW_WR);
    assign wait_load = (next_state != state) &&
                       ((next_state == S_MEMW) || (next_state == S_LW_RD) ||
                        (next_state == S_SW_WR));

    mem_wait_counter u_wait (
        .Clk          (Clk),
        .Reset_signal (Reset_signal),
        .load         (wait_load),
        .load_val     (WAIT_INIT),
        .dec          (wait_dec),
        .count        (wait_cnt),
        .zero         (wait_zero)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  next_state = S_MEMW;
            S_MEMW:   if (wait_zero) next_state = S_DECODE;
            S_DECODE: next_state = dispatch(Op, Funct);
            S_R_EXEC: next_state = (ALU_overflow && is_addsub(funct_q)) ?
                                   S_EXCEPT : S_R_WB;
            S_R_WB:   next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDR:   next_state = (op_q == OP_LW) ? S_LW_RD : S_SW_WR;
            S_LW_RD:  if (wait_zero) next_state = S_LW_WB;
            S_LW_WB:  next_state = S_FETCH;
            S_SW_WR:  if (wait_zero) next_state = S_FETCH;
            S_LUI_WB: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_EXCEPT: next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_RESET;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        wr          = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        A_load      = 1'b0;
        B_load      = 1'b0;
        MDR_load    = 1'b0;
        ALUOut_load = 1'b0;
        EPCWrite    = 1'b0;
        RegReset    = 1'b0;
        MemtoReg    = 2'b00;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALU_sel     = ALU_PASS;
        unique case (state)
            S_RESET: RegReset = 1'b1;
            S_FETCH: begin
                MDR_load = 1'b1;
                IRWrite  = 1'b1;
            end
            S_MEMW: begin
                MDR_load = 1'b1;
                IRWrite  = 1'b1;
                // PC+4 only once the fetch has completed
                if (wait_zero) begin
                    ALUSrcB = 2'b01;
                    ALU_sel = ALU_ADD;
                    PCWrite = 1'b1;
                end
            end
            S_DECODE: begin
                A_load      = 1'b1;
                B_load      = 1'b1;
                ALUOut_load = 1'b1;
                ALUSrcB     = 2'b11;
                ALU_sel     = ALU_ADD;
            end
            S_R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALU_sel     = funct_alu(funct_q);
                ALUOut_load = 1'b1;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_sel     = ALU_SUB;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                BranchNe    = (op_q == OP_BNE);
            end
            S_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_sel     = ALU_ADD;
                ALUOut_load = 1'b1;
            end
            S_LW_RD: begin
                IorD     = 1'b1;
                MDR_load = 1'b1;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_SW_WR: begin
                IorD = 1'b1;
                wr   = 1'b1;
            end
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_EXCEPT: begin
                EPCWrite = 1'b1;
                PCSource = 2'b11;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign PC_load  = PCWrite | (PCWriteCond & (ALU_zero ^ BranchNe));
    assign Halted   = (state == S_HALT);
    assign StateOut = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-stream bench: expands each instruction into its
// expected cycle trace and checks the controller outputs every cycle.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam int MW = 2;

    typedef struct packed {
        logic [7:0] st;
        logic pcl, pcw, pcwc, bne, wr, iord, irw, rw, rdst;
        logic asa, al, bl, mdr, aol, epc, rr;
        logic [1:0] m2r, pcs, asb;
        logic [2:0] alu;
        logic hlt;
    } obs_t;

    logic       Clk;
    logic       Reset_signal;
    logic [5:0] Op, Funct;
    logic       ALU_zero, ALU_overflow;
    logic [7:0] StateOut;
    logic PC_load, PCWrite, PCWriteCond, BranchNe, wr, IorD, IRWrite;
    logic RegWrite, RegDst, ALUSrcA, A_load, B_load, MDR_load;
    logic ALUOut_load, EPCWrite, RegReset, Halted;
    logic [1:0] MemtoReg, PCSource, ALUSrcB;
    logic [2:0] ALU_sel;

    logic       r4, z4, v4;
    logic [5:0] op4, fn4;
    logic [7:0] so4;
    logic d_pcl, d_pcw, d_pcwc, d_bne, d_wr, d_iord, d_irw, rw4, d_rdst;
    logic d_asa, d_al, d_bl, d_mdr, d_aol, d_epc, d_rr, d_hlt;
    logic [1:0] m2r4, d_pcs, d_asb;
    logic [2:0] d_alu;

    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;
    int   rw_count = 0;
    int   hlt_count = 0;
    int   zf = -1;
    obs_t want, cur, last_got;
    logic want_valid = 1'b0;
    logic [5:0] opq = '0, fq = '0;

    mips_multicycle_ctrl #(.MEM_WAIT(MW), .STATE_W(8)) u_dut (
        .Clk(Clk), .Reset_signal(Reset_signal), .Op(Op), .Funct(Funct),
        .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
        .StateOut(StateOut), .PC_load(PC_load), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .wr(wr),
        .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .A_load(A_load),
        .B_load(B_load), .MDR_load(MDR_load), .ALUOut_load(ALUOut_load),
        .EPCWrite(EPCWrite), .RegReset(RegReset), .MemtoReg(MemtoReg),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALU_sel(ALU_sel),
        .Halted(Halted)
    );

    mips_multicycle_ctrl #(.MEM_WAIT(4), .STATE_W(8)) u_dut4 (
        .Clk(Clk), .Reset_signal(r4), .Op(op4), .Funct(fn4),
        .ALU_zero(z4), .ALU_overflow(v4),
        .StateOut(so4), .PC_load(d_pcl), .PCWrite(d_pcw),
        .PCWriteCond(d_pcwc), .BranchNe(d_bne), .wr(d_wr),
        .IorD(d_iord), .IRWrite(d_irw), .RegWrite(rw4),
        .RegDst(d_rdst), .ALUSrcA(d_asa), .A_load(d_al),
        .B_load(d_bl), .MDR_load(d_mdr), .ALUOut_load(d_aol),
        .EPCWrite(d_epc), .RegReset(d_rr), .MemtoReg(m2r4),
        .PCSource(d_pcs), .ALUSrcB(d_asb), .ALU_sel(d_alu),
        .Halted(d_hlt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected strobes for one cycle, straight from the state's role.
    function automatic obs_t expect_of(state_t s, bit last, logic z);
        obs_t e;
        e = '0;
        e.st = 8'(s);
        case (s)
            S_RESET:  e.rr = 1;
            S_FETCH:  begin e.mdr = 1; e.irw = 1; end
            S_MEMW: begin
                e.mdr = 1; e.irw = 1;
                if (last) begin e.asb = 2'b01; e.alu = 3'b001; e.pcw = 1; end
            end
            S_DECODE: begin
                e.al = 1; e.bl = 1; e.aol = 1; e.asb = 2'b11; e.alu = 3'b001;
            end
            S_R_EXEC: begin
                e.asa = 1; e.aol = 1;
                e.alu = (fq == 6'h20) ? 3'b001 : (fq == 6'h22) ? 3'b010 :
                        (fq == 6'h24) ? 3'b011 : 3'b110;
            end
            S_R_WB:   begin e.rw = 1; e.rdst = 1; end
            S_BRANCH: begin
                e.asa = 1; e.alu = 3'b010; e.pcs = 2'b01; e.pcwc = 1;
                e.bne = (opq == 6'h05);
            end
            S_ADDR: begin
                e.asa = 1; e.asb = 2'b10; e.alu = 3'b001; e.aol = 1;
            end
            S_LW_RD:  begin e.iord = 1; e.mdr = 1; end
            S_LW_WB:  begin e.rw = 1; e.m2r = 2'b01; end
            S_SW_WR:  begin e.iord = 1; e.wr = 1; end
            S_LUI_WB: begin e.rw = 1; e.m2r = 2'b10; end
            S_JUMP:   begin e.pcs = 2'b10; e.pcw = 1; end
            S_EXCEPT: begin e.epc = 1; e.pcs = 2'b11; e.pcw = 1; end
            S_HALT:   e.hlt = 1;
            default:  ;
        endcase
        e.pcl = e.pcw | (e.pcwc & (z ^ e.bne));
        return e;
    endfunction

    always @(negedge Clk) begin
        cur = '{st: StateOut, pcl: PC_load, pcw: PCWrite,
                pcwc: PCWriteCond, bne: BranchNe, wr: wr, iord: IorD,
                irw: IRWrite, rw: RegWrite, rdst: RegDst, asa: ALUSrcA,
                al: A_load, bl: B_load, mdr: MDR_load, aol: ALUOut_load,
                epc: EPCWrite, rr: RegReset, m2r: MemtoReg, pcs: PCSource,
                asb: ALUSrcB, alu: ALU_sel, hlt: Halted};
        if (want_valid) begin
            checks++;
            if (cur !== want) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h",
                         $time, cur, want);
            end
            if (cur.rw) rw_count++;
            if (cur.hlt) hlt_count++;
        end
        last_got = cur;
    end

    task automatic check_lit(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, req);
        end
    endtask

    task automatic cycle(input state_t s, input bit last, input logic [5:0] op,
                         input logic [5:0] fn, input logic ovf,
                         input logic rst);
        Op = op;
        Funct = fn;
        ALU_overflow = ovf;
        ALU_zero = (zf < 0) ? 1'($urandom) : 1'(zf);
        Reset_signal = rst;
        want = expect_of(s, last, ALU_zero);
        want_valid = 1'b1;
        ncyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic noise(input state_t s, input bit last);
        cycle(s, last, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic fetch_phase();
        noise(S_FETCH, 0);
        for (int i = 0; i < MW; i++) noise(S_MEMW, i == MW - 1);
    endtask

    // Whole-instruction trace, starting with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf);
        bit addsub;
        fetch_phase();
        cycle(S_DECODE, 0, op, fn, 1'($urandom), 1'b0);
        opq = op;
        fq = fn;
        if (op == 6'h00) begin
            if (fn inside {6'h20, 6'h22, 6'h24, 6'h26}) begin
                addsub = (fn == 6'h20) || (fn == 6'h22);
                cycle(S_R_EXEC, 0, 6'($urandom), 6'($urandom),
                      addsub ? ovf : 1'($urandom), 1'b0);
                if (addsub && ovf) noise(S_EXCEPT, 0);
                else noise(S_R_WB, 0);
            end else if (fn == 6'h0d) begin
                repeat (20) noise(S_HALT, 0);
                cycle(S_HALT, 0, 6'($urandom), 6'($urandom), 1'b0, 1'b1);
                noise(S_RESET, 0);
            end else if (fn != 6'h00) begin
                noise(S_EXCEPT, 0);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            noise(S_BRANCH, 0);
        end else if (op == 6'h23) begin
            noise(S_ADDR, 0);
            for (int i = 0; i < MW; i++) noise(S_LW_RD, 0);
            noise(S_LW_WB, 0);
        end else if (op == 6'h2b) begin
            noise(S_ADDR, 0);
            for (int i = 0; i < MW; i++) noise(S_SW_WR, 0);
        end else if (op == 6'h0f) begin
            noise(S_LUI_WB, 0);
        end else if (op == 6'h02) begin
            noise(S_JUMP, 0);
        end else begin
            noise(S_EXCEPT, 0);
        end
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        ops = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h0f, 6'h02, 6'h3f};
        fns = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h00};
        fn = 6'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom);
        end else begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'h00 && $urandom_range(0, 5) != 0)
                fn = fns[$urandom_range(0, 4)];
        end
    endtask

    initial begin
        int n0, r0, h0, n, mw_n, rd_n;
        bit wb_ok, done;
        logic [5:0] rop, rfn;
        Reset_signal = 1'b1;
        Op = '0; Funct = '0; ALU_zero = 0; ALU_overflow = 0;
        r4 = 1'b1; op4 = 6'h23; fn4 = '0; z4 = 0; v4 = 0;
        @(posedge Clk);
        #1;
        noise(S_RESET, 0);
        check_lit("reset_regreset", int'(last_got.rr), 1);
        check_lit("reset_state", int'(last_got.st), int'(S_RESET));

        n0 = ncyc; r0 = rw_count;
        run_instr(6'h00, 6'h20, 1'b0);
        check_lit("add_cycles", ncyc - n0, 6);
        check_lit("add_rw_cycles", rw_count - r0, 1);
        check_lit("add_last_rw_rdst", {last_got.rw, last_got.rdst}, 3);

        zf = 0;
        fetch_phase();
        cycle(S_DECODE, 0, 6'h05, 6'h00, 1'b0, 1'b0);
        opq = 6'h05;
        noise(S_BRANCH, 0);
        check_lit("bne_nz_pcload", int'(last_got.pcl), 1);
        run_instr(6'h04, 6'h00, 1'b0);
        check_lit("beq_nz_pcload", int'(last_got.pcl), 0);
        zf = -1;

        r0 = rw_count;
        fetch_phase();
        cycle(S_DECODE, 0, 6'h00, 6'h22, 1'b0, 1'b0);
        opq = 6'h00; fq = 6'h22;
        cycle(S_R_EXEC, 0, 6'h00, 6'h20, 1'b1, 1'b0);
        noise(S_EXCEPT, 0);
        check_lit("sub_ovf_epc_pcs", {last_got.epc, last_got.pcs}, 7);
        run_instr(6'h00, 6'h00, 1'b0);
        check_lit("sub_ovf_no_rw", rw_count - r0, 0);

        run_instr(6'h3f, 6'h00, 1'b0);
        check_lit("op3f_except", int'(last_got.st), int'(S_EXCEPT));

        h0 = hlt_count;
        run_instr(6'h00, 6'h0d, 1'b0);
        check_lit("halt_cycles", hlt_count - h0, 21);
        check_lit("halt_reset_state", int'(last_got.st), int'(S_RESET));

        noise(S_FETCH, 0);
        cycle(S_MEMW, 0, 6'h00, 6'h00, 1'b0, 1'b1);
        noise(S_RESET, 0);

        fetch_phase();
        cycle(S_DECODE, 0, 6'h2b, 6'h00, 1'b0, 1'b0);
        opq = 6'h2b;
        noise(S_ADDR, 0);
        noise(S_SW_WR, 0);
        cycle(S_SW_WR, 0, 6'h00, 6'h00, 1'b0, 1'b1);
        noise(S_RESET, 0);
        check_lit("sw_reset_wr", int'(last_got.wr), 0);
        check_lit("sw_reset_state", int'(last_got.st), int'(S_RESET));

        for (int k = 0; k < 300; k++) begin
            pick(rop, rfn);
            run_instr(rop, rfn, 1'($urandom));
        end

        want_valid = 1'b0;
        Reset_signal = 1'b1;
        r4 = 1'b1;
        @(posedge Clk);
        #1;
        r4 = 1'b0;
        @(posedge Clk);
        #1;
        n = 0; mw_n = 0; rd_n = 0; wb_ok = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge Clk);
            if (n > 0 && so4 == 8'(S_FETCH)) begin
                done = 1;
            end else begin
                n++;
                if (so4 == 8'(S_MEMW)) mw_n++;
                if (so4 == 8'(S_LW_RD)) rd_n++;
                if (so4 == 8'(S_LW_WB) && rw4 && m2r4 == 2'b01) wb_ok = 1;
            end
        end
        check_lit("lw4_done", int'(done), 1);
        check_lit("lw4_cycles", n, 12);
        check_lit("lw4_memw", mw_n, 4);
        check_lit("lw4_lwrd", rd_n, 4);
        check_lit("lw4_wb_mdr", int'(wb_ok), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
